// File: rtl/ntt_scheduler.sv
// Address/control sequencer for one in-place NTT or INTT pass over 256 coefficients.
// Issues one butterfly per cycle and delays each issued address pair to the write port.
module ntt_scheduler #(
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_intt,
    input  logic       i_algo,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr_a,
    output logic [7:0] o_rd_addr_b,
    output logic [7:0] o_tw_addr,
    output logic       o_bfu_intt,
    output logic       o_bfu_algo,
    output logic       o_bfu_skip,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr_a,
    output logic [7:0] o_wr_addr_b,
    output logic [1:0] o_dbg_state
);

    localparam int D = RD_LAT + BFU_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic [2:0]  lvl_q;
    logic        intt_q;
    logic        algo_q;
    logic [16:0] dly_q [D];

    logic [7:0] c_d;
    logic [7:0] len_d;
    logic [7:0] g_d;
    logic [7:0] rd_a_d;
    logic [7:0] rd_b_d;
    logic [7:0] tw_d;
    logic [2:0] lmin_d;
    logic       last_layer_d;

    // Butterfly c of layer L pairs j with j+len; g is the group, which selects the twiddle.
    always_comb begin
        c_d    = {1'b0, cnt_q};
        len_d  = 8'd1 << lvl_q;
        g_d    = c_d >> lvl_q;
        rd_a_d = (g_d << ({1'b0, lvl_q} + 4'd1)) | (c_d & (len_d - 8'd1));
        rd_b_d = rd_a_d + len_d;
        tw_d   = intt_q ? ((8'hFF >> lvl_q) - g_d) : ((8'd128 >> lvl_q) + g_d);
        lmin_d = {2'b00, ~algo_q};
        last_layer_d = intt_q ? (lvl_q == 3'd7) : (lvl_q == lmin_d);
    end

    assign o_bfu_skip  = 1'b0;
    assign o_dbg_state = state_q;
    assign o_wr_en     = dly_q[D-1][16];
    assign o_wr_addr_a = dly_q[D-1][15:8];
    assign o_wr_addr_b = dly_q[D-1][7:0];

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lvl_q       <= '0;
            intt_q      <= 1'b0;
            algo_q      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_addr   <= '0;
            o_bfu_intt  <= 1'b0;
            o_bfu_algo  <= 1'b0;
            for (int i = 0; i < D; i++) dly_q[i] <= '0;
        end else begin
            o_busy      <= (state_q != IDLE);
            o_done      <= (state_q == DONE);
            o_rd_en     <= (state_q == RUN);
            o_rd_addr_a <= (state_q == RUN) ? rd_a_d : 8'd0;
            o_rd_addr_b <= (state_q == RUN) ? rd_b_d : 8'd0;
            o_tw_addr   <= (state_q == RUN) ? tw_d : 8'd0;
            o_bfu_intt  <= intt_q;
            o_bfu_algo  <= algo_q;

            dly_q[0] <= {o_rd_en, o_rd_addr_a, o_rd_addr_b};
            for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];

            case (state_q)
                IDLE: begin
                    // A start seen while o_done is still showing belongs to the finished pass.
                    if (i_start && !o_done) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        intt_q  <= i_intt;
                        algo_q  <= i_algo;
                        lvl_q   <= i_intt ? {2'b00, ~i_algo} : 3'd7;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'd127) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'(D - 1)) begin
                        cnt_q <= '0;
                        if (last_layer_d) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                            lvl_q   <= intt_q ? lvl_q + 3'd1 : lvl_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_scheduler.sv
// Bench for ntt_scheduler: RAM + BFU model driven by the DUT addresses, compared against
// a textbook loop-nest NTT, with read/write address scoreboards and latency checks.
module tb_ntt_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, intt, algo;
    logic       busy, done, rd_en, bfu_intt, bfu_algo, bfu_skip, wr_en;
    logic [7:0] rd_a, rd_b, tw, wr_a, wr_b;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ntt_scheduler dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_intt      (intt),
        .i_algo      (algo),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_addr_a (rd_a),
        .o_rd_addr_b (rd_b),
        .o_tw_addr   (tw),
        .o_bfu_intt  (bfu_intt),
        .o_bfu_algo  (bfu_algo),
        .o_bfu_skip  (bfu_skip),
        .o_wr_en     (wr_en),
        .o_wr_addr_a (wr_a),
        .o_wr_addr_b (wr_b),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        bit          algo;
        bit          intt;
        int          lat;
        int          layers;
        logic [23:0] first;
    } vec_t;

    vec_t        tbl [4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [23:0] exp_q [$];
    logic [15:0] exp_wr_q [$];
    int          exp_wr_cyc_q [$];
    logic [47:0] res_q [$];
    longint      mem [256];
    longint      ref_mem [256];
    int          pend [256];
    longint      q_mod;
    bit          exp_intt, exp_algo;
    int          rd_cnt;
    logic [23:0] first_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint zeta(input int k, input longint q);
        return (longint'(k) * 1753 + 17) % q;
    endfunction

    task automatic bfly(input longint x, input longint y, input longint w, input bit inv,
                        output longint ao, output longint bo);
        longint t;
        if (!inv) begin
            t  = (y * w) % q_mod;
            ao = (x + t) % q_mod;
            bo = (x - t + q_mod) % q_mod;
        end else begin
            ao = (x + y) % q_mod;
            bo = (((x - y + q_mod) % q_mod) * w) % q_mod;
        end
    endtask

    // Textbook Cooley-Tukey / Gentleman-Sande loop nests: expected read order and final RAM.
    task automatic build_model(input bit a_algo, input bit a_intt);
        int     k, lmin_len;
        longint ao, bo;
        lmin_len = a_algo ? 1 : 2;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        if (!a_intt) begin
            k = 1;
            for (int len = 128; len >= lmin_len; len = len / 2) begin
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                        bfly(ref_mem[j], ref_mem[j+len], zeta(k, q_mod), 1'b0, ao, bo);
                        ref_mem[j] = ao;
                        ref_mem[j+len] = bo;
                    end
                    k++;
                end
            end
        end else begin
            k = a_algo ? 255 : 127;
            for (int len = lmin_len; len <= 128; len = len * 2) begin
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
                        bfly(ref_mem[j], ref_mem[j+len], zeta(k, q_mod), 1'b1, ao, bo);
                        ref_mem[j] = ao;
                        ref_mem[j+len] = bo;
                    end
                    k--;
                end
            end
        end
    endtask

    // Monitor: RAM read (1 cycle) + BFU (4 cycles) model, read/write scoreboards, hazard tracking.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                logic [23:0] e;
                longint      ao, bo;
                rd_cnt++;
                if (rd_cnt == 1) first_rd = {rd_a, rd_b, tw};
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_addr_a", rd_a, e[23:16]);
                    check("rd_addr_b", rd_b, e[15:8]);
                    check("tw_addr", tw, e[7:0]);
                end
                check("raw_hazard", (pend[rd_a] != 0 || pend[rd_b] != 0) ? 1 : 0, 0);
                pend[rd_a]++;
                pend[rd_b]++;
                bfly(mem[rd_a], mem[rd_b], zeta(int'(tw), q_mod), exp_intt, ao, bo);
                res_q.push_back({24'(ao), 24'(bo)});
                exp_wr_q.push_back({rd_a, rd_b});
                exp_wr_cyc_q.push_back(cyc + 5);
            end
            if (wr_en) begin
                logic [15:0] ew;
                logic [47:0] r;
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    ew = exp_wr_q.pop_front();
                    r  = res_q.pop_front();
                    check("wr_addr_a", wr_a, ew[15:8]);
                    check("wr_addr_b", wr_b, ew[7:0]);
                    check("wr_latency", cyc, exp_wr_cyc_q.pop_front());
                    mem[wr_a] = longint'(r[47:24]);
                    mem[wr_b] = longint'(r[23:0]);
                    pend[wr_a]--;
                    pend[wr_b]--;
                end
            end
            if (busy) begin
                check("bfu_intt", bfu_intt, exp_intt);
                check("bfu_algo", bfu_algo, exp_algo);
                check("bfu_skip", bfu_skip, 0);
            end
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        exp_wr_q.delete();
        exp_wr_cyc_q.delete();
        res_q.delete();
        for (int i = 0; i < 256; i++) pend[i] = 0;
    endtask

    task automatic run_pass(input int idx, input bit disturb);
        vec_t v;
        int   t0, t_done, bad;
        bit   seen;
        v = tbl[idx];
        q_mod = v.algo ? 64'd8380417 : 64'd3329;
        for (int i = 0; i < 256; i++) mem[i] = longint'($urandom_range(0, int'(q_mod) - 1));
        clear_sb();
        build_model(v.algo, v.intt);
        exp_intt = v.intt;
        exp_algo = v.algo;
        rd_cnt   = 0;
        first_rd = '0;
        mon_en   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        intt  = v.intt;
        algo  = v.algo;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        t_done = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                t_done = cyc;
                start  = 1'b1;
                intt   = 1'($urandom_range(0, 1));
                algo   = 1'($urandom_range(0, 1));
            end else if (disturb) begin
                start = 1'($urandom_range(0, 1));
                intt  = 1'($urandom_range(0, 1));
                algo  = 1'($urandom_range(0, 1));
            end
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", t_done - t0, v.lat);
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", busy, 0);
            @(negedge clk);
            check("idle_after_done", busy, 0);
        end
        start  = 1'b0;
        mon_en = 1'b0;
        check("issue_count", rd_cnt, v.layers * 128);
        check("first_read", first_rd, v.first);
        check("rd_queue_empty", exp_q.size(), 0);
        check("wr_queue_empty", exp_wr_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) bad++;
        check("ram_vs_reference", bad, 0);
    endtask

    initial begin
        tbl[0] = '{algo: 1'b0, intt: 1'b0, lat: 933,  layers: 7, first: {8'd0, 8'd128, 8'd1}};
        tbl[1] = '{algo: 1'b1, intt: 1'b0, lat: 1066, layers: 8, first: {8'd0, 8'd128, 8'd1}};
        tbl[2] = '{algo: 1'b0, intt: 1'b1, lat: 933,  layers: 7, first: {8'd0, 8'd2, 8'd127}};
        tbl[3] = '{algo: 1'b1, intt: 1'b1, lat: 1066, layers: 8, first: {8'd0, 8'd1, 8'd255}};

        rst = 1'b1; start = 1'b0; intt = 1'b0; algo = 1'b0;
        q_mod = 64'd3329;
        clear_sb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", {rd_a, rd_b, tw}, 0);
        check("rst_wr_addr", {wr_a, wr_b}, 0);
        check("rst_mode", {bfu_intt, bfu_algo, bfu_skip}, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_pass(i, 1'b0);

        // Start and mode inputs wiggled throughout a Kyber NTT pass.
        run_pass(0, 1'b1);

        // Reset 300 cycles into a pass, then a clean pass.
        @(negedge clk);
        start = 1'b1; intt = 1'b0; algo = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_no_write", wr_en, 0);
        run_pass(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
